// File: rtl/isp_interp_pkg.sv
// Shared constants for the multi-channel 2x2 bilinear interpolator.
package isp_interp_pkg;

    localparam int unsigned FW_DEF        = 5;
    localparam int unsigned S             = 32'd1 << FW_DEF;
    localparam int unsigned HALF_RND      = 32'd1 << (2 * FW_DEF - 1);
    localparam logic        MODE_BILINEAR = 1'b0;
    localparam logic        MODE_NEAREST  = 1'b1;
    localparam int unsigned LAT           = 4;

    // Fraction scale 2**fw for an arbitrary fraction width.
    function automatic int unsigned scale_of(input int unsigned fw);
        return 32'd1 << fw;
    endfunction

endpackage

// File: rtl/interp_lerp1d.sv
// Registered one-dimensional blend y = a*(S-f) + b*f, exact in W+FW bits.
module interp_lerp1d
    import isp_interp_pkg::*;
#(
    parameter int unsigned W  = 8,
    parameter int unsigned FW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en_i,
    input  logic [W-1:0]    a_i,
    input  logic [W-1:0]    b_i,
    input  logic [FW-1:0]   f_i,
    output logic [W+FW-1:0] y_o
);

    localparam int unsigned YW = W + FW;

    logic [YW-1:0] sf;
    logic [YW-1:0] y_d;
    logic [YW-1:0] y_q;

    // Each product and the sum are bounded by (2**W-1)*2**FW, so YW bits are exact.
    assign sf  = YW'(scale_of(FW)) - YW'(f_i);
    assign y_d = YW'(a_i) * sf + YW'(b_i) * YW'(f_i);

    always_ff @(posedge clk) begin
        if (!rst) begin
            y_q <= '0;
        end else if (en_i) begin
            y_q <= y_d;
        end
    end

    assign y_o = y_q;

endmodule

// File: rtl/bilinear_interp_pipe.sv
// Four-stage multi-channel 2x2 interpolator with bilinear/nearest modes,
// valid/ready backpressure and a sideband carried alongside each sample.
module bilinear_interp_pipe
    import isp_interp_pkg::*;
#(
    parameter int unsigned DW     = 8,
    parameter int unsigned FW     = 5,
    parameter int unsigned CH     = 3,
    parameter int unsigned USER_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_vld,
    output logic              i_rdy,
    input  logic              i_mode,
    input  logic [FW-1:0]     frac_w,
    input  logic [FW-1:0]     frac_h,
    input  logic [CH*DW-1:0]  d0,
    input  logic [CH*DW-1:0]  d1,
    input  logic [CH*DW-1:0]  d2,
    input  logic [CH*DW-1:0]  d3,
    input  logic [USER_W-1:0] i_user,
    output logic [CH*DW-1:0]  o_d,
    output logic [USER_W-1:0] o_user,
    output logic              o_vld,
    input  logic              o_rdy
);

    localparam int unsigned PW   = CH * DW;
    localparam int unsigned HW   = DW + FW;
    localparam int unsigned AW   = DW + 2 * FW;
    localparam int unsigned HALF = 32'd1 << (2 * FW - 1);

    logic                         en;
    logic [PW-1:0]                d0_q, d1_q, d2_q, d3_q;
    logic [FW-1:0]                fw_q, fh_q, fh2_q;
    logic [PW-1:0]                nn_d, nn2_q, nn3_q;
    logic [PW-1:0]                rnd_w;
    logic [PW-1:0]                o_d_d, o_d_q;
    logic [LAT-1:0]               vld_q;
    logic [LAT-1:0][USER_W-1:0]   user_q;
    logic [LAT-2:0]               mode_q;
    logic [HW-1:0]                top_w [CH];
    logic [HW-1:0]                bot_w [CH];
    logic [AW-1:0]                acc_w [CH];

    // Whole pipeline advances together unless the output is held by the sink.
    assign en    = ~o_vld | o_rdy;
    assign i_rdy = en;

    for (genvar c = 0; c < CH; c++) begin : g_ch
        interp_lerp1d #(.W(DW), .FW(FW)) u_top (
            .clk (clk), .rst (rst), .en_i (en),
            .a_i (d0_q[c*DW +: DW]), .b_i (d1_q[c*DW +: DW]),
            .f_i (fw_q), .y_o (top_w[c])
        );
        interp_lerp1d #(.W(DW), .FW(FW)) u_bot (
            .clk (clk), .rst (rst), .en_i (en),
            .a_i (d2_q[c*DW +: DW]), .b_i (d3_q[c*DW +: DW]),
            .f_i (fw_q), .y_o (bot_w[c])
        );
        interp_lerp1d #(.W(HW), .FW(FW)) u_vert (
            .clk (clk), .rst (rst), .en_i (en),
            .a_i (top_w[c]), .b_i (bot_w[c]),
            .f_i (fh2_q), .y_o (acc_w[c])
        );

        // Fraction MSB set means f >= S/2, i.e. the far neighbour is nearer.
        assign nn_d[c*DW +: DW] = fw_q[FW-1]
            ? (fh_q[FW-1] ? d3_q[c*DW +: DW] : d1_q[c*DW +: DW])
            : (fh_q[FW-1] ? d2_q[c*DW +: DW] : d0_q[c*DW +: DW]);

        // acc + HALF stays below 2**AW because acc <= (2**DW-1)*S*S.
        assign rnd_w[c*DW +: DW] = DW'((acc_w[c] + AW'(HALF)) >> (2 * FW));
    end

    always_comb begin
        o_d_d = rnd_w;
        if (mode_q[LAT-2] == MODE_NEAREST) begin
            o_d_d = nn3_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            d0_q   <= '0;
            d1_q   <= '0;
            d2_q   <= '0;
            d3_q   <= '0;
            fw_q   <= '0;
            fh_q   <= '0;
            fh2_q  <= '0;
            nn2_q  <= '0;
            nn3_q  <= '0;
            o_d_q  <= '0;
            vld_q  <= '0;
            user_q <= '0;
            mode_q <= '0;
        end else if (en) begin
            d0_q   <= d0;
            d1_q   <= d1;
            d2_q   <= d2;
            d3_q   <= d3;
            fw_q   <= frac_w;
            fh_q   <= frac_h;
            fh2_q  <= fh_q;
            nn2_q  <= nn_d;
            nn3_q  <= nn2_q;
            o_d_q  <= o_d_d;
            vld_q  <= {vld_q[LAT-2:0], i_vld};
            user_q <= {user_q[LAT-2:0], i_user};
            mode_q <= {mode_q[LAT-3:0], i_mode};
        end
    end

    assign o_d    = o_d_q;
    assign o_vld  = vld_q[LAT-1];
    assign o_user = user_q[LAT-1];

endmodule

// File: tb/tb_bilinear_interp_pipe.sv
// Scoreboard bench for bilinear_interp_pipe: directed cases, random vectors,
// backpressure and mid-stream reset.
module tb_bilinear_interp_pipe;

    localparam int DW = 8;
    localparam int FW = 5;
    localparam int CH = 3;
    localparam int UW = 2;
    localparam int PW = CH * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_vld = 1'b0;
    logic          i_rdy;
    logic          i_mode = 1'b0;
    logic [FW-1:0] frac_w = '0;
    logic [FW-1:0] frac_h = '0;
    logic [PW-1:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
    logic [UW-1:0] i_user = '0;
    logic [PW-1:0] o_d;
    logic [UW-1:0] o_user;
    logic          o_vld;
    logic          o_rdy = 1'b1;

    typedef struct {
        logic [PW-1:0] d;
        logic [UW-1:0] user;
        int            cyc;
        bit            chk;
    } exp_t;

    exp_t          sb[$];
    int            n_cmp = 0;
    int            n_err = 0;
    int            cyc = 0;
    bit            chk_lat = 1'b0;
    bit            rdy_rand = 1'b0;
    int            stall_cnt = 0;
    bit            stall_q = 1'b0;
    logic [PW-1:0] hold_d;
    logic [UW-1:0] hold_u;

    bilinear_interp_pipe #(.DW(DW), .FW(FW), .CH(CH), .USER_W(UW)) dut (
        .clk    (clk),
        .rst    (rst),
        .i_vld  (i_vld),
        .i_rdy  (i_rdy),
        .i_mode (i_mode),
        .frac_w (frac_w),
        .frac_h (frac_h),
        .d0     (d0),
        .d1     (d1),
        .d2     (d2),
        .d3     (d3),
        .i_user (i_user),
        .o_d    (o_d),
        .o_user (o_user),
        .o_vld  (o_vld),
        .o_rdy  (o_rdy)
    );

    always #5 clk = ~clk;

    // Reference: the exact integer formula, or nearest-neighbour pick.
    function automatic logic [PW-1:0] model(input logic [PW-1:0] a, b, c, d,
                                            input int fw, fh, input logic mode);
        logic [PW-1:0] r;
        int p0, p1, p2, p3, top, bot, acc;
        r = '0;
        for (int ch = 0; ch < CH; ch++) begin
            p0 = int'(a[ch*DW +: DW]);
            p1 = int'(b[ch*DW +: DW]);
            p2 = int'(c[ch*DW +: DW]);
            p3 = int'(d[ch*DW +: DW]);
            if (mode) begin
                if (fh >= 16) r[ch*DW +: DW] = DW'((fw >= 16) ? p3 : p2);
                else          r[ch*DW +: DW] = DW'((fw >= 16) ? p1 : p0);
            end else begin
                top = p0 * (32 - fw) + p1 * fw;
                bot = p2 * (32 - fw) + p3 * fw;
                acc = top * (32 - fh) + bot * fh;
                r[ch*DW +: DW] = DW'((acc + 512) >> 10);
            end
        end
        return r;
    endfunction

    // Sink ready: on, random, or forced low for stall_cnt cycles.
    initial forever begin
        @(posedge clk);
        #1;
        if (stall_cnt > 0) begin
            o_rdy = 1'b0;
            stall_cnt--;
        end else if (rdy_rand) begin
            o_rdy = 1'($urandom_range(1));
        end else begin
            o_rdy = 1'b1;
        end
    end

    // Monitor: push on input transfer, pop and compare on output transfer.
    initial forever begin
        exp_t e;
        @(negedge clk);
        cyc++;
        if (!rst) begin
            sb.delete();
            stall_q = 1'b0;
        end else begin
            n_cmp++;
            assert (i_rdy === ~(o_vld & ~o_rdy)) else begin
                n_err++;
                $error("FAIL i_rdy got %b exp %b", i_rdy, ~(o_vld & ~o_rdy));
            end
            if (stall_q) begin
                n_cmp++;
                assert (o_vld === 1'b1 && o_d === hold_d && o_user === hold_u) else begin
                    n_err++;
                    $error("FAIL stall_hold got vld=%b d=%h u=%h exp vld=1 d=%h u=%h",
                           o_vld, o_d, o_user, hold_d, hold_u);
                end
            end
            if (i_vld && i_rdy)
                sb.push_back('{model(d0, d1, d2, d3, int'(frac_w), int'(frac_h), i_mode),
                               i_user, cyc, chk_lat});
            if (o_vld && o_rdy) begin
                n_cmp++;
                assert (sb.size() != 0) else begin
                    n_err++;
                    $error("FAIL spurious_out got d=%h exp no output", o_d);
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    n_cmp++;
                    assert (o_d === e.d && o_user === e.user) else begin
                        n_err++;
                        $error("FAIL data got d=%h u=%h exp d=%h u=%h", o_d, o_user, e.d, e.user);
                    end
                    if (e.chk) begin
                        n_cmp++;
                        assert (cyc - e.cyc === 4) else begin
                            n_err++;
                            $error("FAIL latency got %0d exp 4", cyc - e.cyc);
                        end
                    end
                end
            end
            stall_q = o_vld & ~o_rdy;
            hold_d  = o_d;
            hold_u  = o_user;
        end
    end

    task automatic send(input logic [PW-1:0] a, b, c, d, input logic [FW-1:0] fw, fh,
                        input logic mode, input logic [UW-1:0] u);
        int k;
        bit acc;
        i_vld = 1'b1; d0 = a; d1 = b; d2 = c; d3 = d;
        frac_w = fw; frac_h = fh; i_mode = mode; i_user = u;
        k = 0;
        acc = 1'b0;
        while (!acc && k < 1000) begin
            @(negedge clk);
            acc = i_rdy;
            @(posedge clk);
            #1;
            k++;
        end
        i_vld = 1'b0;
        n_cmp++;
        assert (acc) else begin
            n_err++;
            $error("FAIL send_timeout got no accept exp accept within 1000 cycles");
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 2000) begin
            @(posedge clk);
            k++;
        end
        n_cmp++;
        assert (sb.size() == 0) else begin
            n_err++;
            $error("FAIL drain got %0d pending exp 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout got hang exp finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        assert (o_vld === 1'b0 && o_d === '0 && o_user === '0 && i_rdy === 1'b1) else begin
            n_err++;
            $error("FAIL reset_state got vld=%b d=%h u=%h rdy=%b exp 0/0/0/1",
                   o_vld, o_d, o_user, i_rdy);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Midpoint, with latency check
        chk_lat = 1'b1;
        send({3{8'd10}}, {3{8'd20}}, {3{8'd30}}, {3{8'd40}}, 5'd16, 5'd16, 1'b0, 2'b01);
        chk_lat = 1'b0;
        // Rounding half-up and just below half
        send({3{8'd0}}, {3{8'd1}}, {3{8'd0}}, {3{8'd0}}, 5'd16, 5'd0, 1'b0, 2'b10);
        send({3{8'd0}}, {3{8'd1}}, {3{8'd0}}, {3{8'd0}}, 5'd15, 5'd0, 1'b0, 2'b11);
        // Extremes
        send({3{8'd255}}, {3{8'd255}}, {3{8'd255}}, {3{8'd255}}, 5'd31, 5'd31, 1'b0, 2'b00);
        send({3{8'd0}}, {3{8'd0}}, {3{8'd0}}, {3{8'd0}}, 5'd31, 5'd31, 1'b0, 2'b01);
        send({8'd77, 8'd12, 8'd200}, {3{8'd9}}, {3{8'd99}}, {3{8'd250}}, 5'd0, 5'd0, 1'b0, 2'b10);
        // Nearest neighbour
        send({3{8'd1}}, {3{8'd2}}, {3{8'd3}}, {3{8'd4}}, 5'd16, 5'd15, 1'b1, 2'b00);
        send({3{8'd1}}, {3{8'd2}}, {3{8'd3}}, {3{8'd4}}, 5'd15, 5'd16, 1'b1, 2'b01);
        send({3{8'd1}}, {3{8'd2}}, {3{8'd3}}, {3{8'd4}}, 5'd31, 5'd31, 1'b1, 2'b10);
        drain();

        // Random vectors
        for (int i = 0; i < 10000; i++)
            send(PW'($urandom), PW'($urandom), PW'($urandom), PW'($urandom),
                 FW'($urandom), FW'($urandom), 1'($urandom_range(1)), UW'($urandom));
        drain();

        // Backpressure stream: fixed stall, then random sink
        for (int i = 0; i < 20; i++) begin
            if (i == 6) stall_cnt = 3;
            if (i == 9) rdy_rand = 1'b1;
            send(PW'($urandom), PW'($urandom), PW'($urandom), PW'($urandom),
                 FW'($urandom), FW'($urandom), 1'($urandom_range(1)), UW'(i));
        end
        drain();
        rdy_rand = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset with three samples in flight
        for (int i = 0; i < 3; i++)
            send({3{8'd200}}, {3{8'd201}}, {3{8'd202}}, {3{8'd203}}, 5'd7, 5'd9, 1'b0, 2'b11);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        assert (o_vld === 1'b0 && i_rdy === 1'b1) else begin
            n_err++;
            $error("FAIL post_reset got vld=%b rdy=%b exp 0/1", o_vld, i_rdy);
        end
        @(posedge clk);
        #1;
        chk_lat = 1'b1;
        send({3{8'd5}}, {3{8'd6}}, {3{8'd7}}, {3{8'd8}}, 5'd3, 5'd29, 1'b0, 2'b01);
        chk_lat = 1'b0;
        drain();
        repeat (10) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
